// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascon_pkg
// Description : Shared types and constants for the Ascon AD absorb stage:
//               round-constant table, S-box table, FSM encoding, state type.
//               The PAD state exists only when ASCON_AD_PAD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_pkg;

    localparam int ROUND_MAX = 12;
    localparam int RATE_W    = 64;

    // x0..x4; index 0 is x0
    typedef logic [4:0][RATE_W-1:0] ascon_state_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_AD = 3'd1,
        ST_PERM    = 3'd2,
`ifdef ASCON_AD_PAD_EN
        ST_PAD     = 3'd3,
`endif
        ST_DONE    = 3'd4
    } ascon_fsm_e;

    // Round constants for round indices 0..11 (entry 0 is rightmost)
    localparam logic [11:0][7:0] RC_TABLE = {
        8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
        8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0
    };

    // 5-bit S-box; input/output bit 4 is x0, bit 0 is x4 (entry 0 rightmost)
    localparam logic [31:0][4:0] SBOX = {
        5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
        5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
        5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
        5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
    };

    // Indices past the table yield zero rather than an undefined lookup
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        logic [7:0] rc;
        rc = 8'h00;
        if (idx < 4'(ROUND_MAX)) begin
            rc = RC_TABLE[idx];
        end
        return rc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_round.sv
`default_nettype none
// ============================================================================
// Module      : ascon_round
// Description : One combinational Ascon permutation round: constant addition
//               into x2, bit-sliced 5-bit S-box layer, linear diffusion layer.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t state_i,
    input  logic [3:0]   round_i,
    output ascon_state_t state_o
);

    ascon_state_t w_add;
    ascon_state_t w_sub;

    // Constant addition touches only the low byte of x2
    always_comb begin
        w_add    = state_i;
        w_add[2] = state_i[2] ^ {56'h0, round_const(round_i)};
    end

    // S-box applied independently to every bit column {x0,x1,x2,x3,x4}
    generate
        for (genvar b = 0; b < RATE_W; b++) begin : g_sbox
            logic [4:0] w_col_in;
            logic [4:0] w_col_out;
            assign w_col_in     = {w_add[0][b], w_add[1][b], w_add[2][b], w_add[3][b], w_add[4][b]};
            assign w_col_out    = SBOX[w_col_in];
            assign w_sub[0][b]  = w_col_out[4];
            assign w_sub[1][b]  = w_col_out[3];
            assign w_sub[2][b]  = w_col_out[2];
            assign w_sub[3][b]  = w_col_out[1];
            assign w_sub[4][b]  = w_col_out[0];
        end
    endgenerate

    // Linear layer: each word XORed with two right-rotations of itself
    assign state_o[0] = w_sub[0] ^ {w_sub[0][18:0], w_sub[0][63:19]} ^ {w_sub[0][27:0], w_sub[0][63:28]};
    assign state_o[1] = w_sub[1] ^ {w_sub[1][60:0], w_sub[1][63:61]} ^ {w_sub[1][38:0], w_sub[1][63:39]};
    assign state_o[2] = w_sub[2] ^ {w_sub[2][0],    w_sub[2][63:1]}  ^ {w_sub[2][5:0],  w_sub[2][63:6]};
    assign state_o[3] = w_sub[3] ^ {w_sub[3][9:0],  w_sub[3][63:10]} ^ {w_sub[3][16:0], w_sub[3][63:17]};
    assign state_o[4] = w_sub[4] ^ {w_sub[4][6:0],  w_sub[4][63:7]}  ^ {w_sub[4][40:0], w_sub[4][63:41]};

endmodule
`default_nettype wire

// File: rtl/ascon_ad_absorb.sv
`default_nettype none
// ============================================================================
// Module      : ascon_ad_absorb
// Description : Ascon associated-data absorb stage. Loads the post-init
//               state, XORs each 64-bit AD block into x0, runs ROUNDS_B
//               rounds per block (one per cycle) and applies the domain
//               separation bit to x4 at the end.
//               Optional macro ASCON_AD_PAD_EN: hardware padding of the last
//               block using ad_bytes_i, with an extra padding block when the
//               last block is full.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_ad_absorb
    import ascon_pkg::*;
#(
    parameter int ROUNDS_B = 6
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  ascon_state_t       state_i,
    input  logic [127:0]       key_i,
    input  logic               ad_empty_i,
    input  logic               ad_valid_i,
    output logic               ad_ready_o,
    input  logic [RATE_W-1:0]  ad_data_i,
    input  logic               ad_last_i,
`ifdef ASCON_AD_PAD_EN
    input  logic [3:0]         ad_bytes_i,
`endif
    output logic               busy_o,
    output logic               done_o,
    output ascon_state_t       state_o,
    output logic               intr_o
);

    localparam logic [3:0] c_round_start = 4'(ROUND_MAX - ROUNDS_B);
    localparam logic [3:0] c_round_last  = 4'(ROUND_MAX - 1);
`ifdef ASCON_AD_PAD_EN
    localparam logic [RATE_W-1:0] c_pad_word = {1'b1, {(RATE_W-1){1'b0}}};
`endif

    ascon_fsm_e         r_fsm;
    ascon_fsm_e         w_fsm_next;
    ascon_state_t       r_state;
    ascon_state_t       w_state_next;
    ascon_state_t       w_round_out;
    logic [3:0]         r_round;
    logic [3:0]         w_round_next;
    logic               r_last;       // block being permuted is the final one
    logic               w_last_next;
    logic [RATE_W-1:0]  w_ad_block;
`ifdef ASCON_AD_PAD_EN
    logic               r_full;       // final block was full, padding block pending
    logic               w_full_next;
`endif

    ascon_round u_round (
        .state_i (r_state),
        .round_i (r_round),
        .state_o (w_round_out)
    );

`ifdef ASCON_AD_PAD_EN
    // Short last block: keep the top n bytes, put 0x80 at byte n, clear the rest
    always_comb begin
        w_ad_block = ad_data_i;
        if (ad_last_i && (ad_bytes_i < 4'd8)) begin
            w_ad_block = (ad_data_i & ~({RATE_W{1'b1}} >> {ad_bytes_i[2:0], 3'b000}))
                       | (c_pad_word >> {ad_bytes_i[2:0], 3'b000});
        end
    end
`else
    assign w_ad_block = ad_data_i;
`endif

    // Next-state and datapath update for the absorb sequence
    always_comb begin
        w_fsm_next   = r_fsm;
        w_state_next = r_state;
        w_round_next = r_round;
        w_last_next  = r_last;
`ifdef ASCON_AD_PAD_EN
        w_full_next  = r_full;
`endif
        case (r_fsm)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_next    = state_i;
                    w_state_next[3] = state_i[3] ^ key_i[127:64];
                    w_state_next[4] = state_i[4] ^ key_i[63:0];
                    w_round_next    = c_round_start;
                    w_last_next     = 1'b0;
`ifdef ASCON_AD_PAD_EN
                    w_full_next     = 1'b0;
`endif
                    if (ad_empty_i) begin
                        w_state_next[4][0] = w_state_next[4][0] ^ 1'b1;
                        w_fsm_next         = ST_DONE;
                    end else begin
                        w_fsm_next = ST_WAIT_AD;
                    end
                end
            end
            ST_WAIT_AD: begin
                if (ad_valid_i) begin
                    w_state_next[0] = r_state[0] ^ w_ad_block;
                    w_last_next     = ad_last_i;
`ifdef ASCON_AD_PAD_EN
                    w_full_next     = ad_last_i && (ad_bytes_i >= 4'd8);
`endif
                    w_round_next    = c_round_start;
                    w_fsm_next      = ST_PERM;
                end
            end
            ST_PERM: begin
                w_state_next = w_round_out;
                if (r_round == c_round_last) begin
                    w_round_next = c_round_start;
                    if (!r_last) begin
                        w_fsm_next = ST_WAIT_AD;
`ifdef ASCON_AD_PAD_EN
                    end else if (r_full) begin
                        w_fsm_next = ST_PAD;
`endif
                    end else begin
                        w_state_next[4][0] = w_round_out[4][0] ^ 1'b1;
                        w_fsm_next         = ST_DONE;
                    end
                end else begin
                    w_round_next = r_round + 4'd1;
                end
            end
`ifdef ASCON_AD_PAD_EN
            ST_PAD: begin
                w_state_next[0] = r_state[0] ^ c_pad_word;
                w_full_next     = 1'b0;
                w_round_next    = c_round_start;
                w_fsm_next      = ST_PERM;
            end
`endif
            ST_DONE: begin
                w_fsm_next = ST_IDLE;
            end
            default: begin
                w_fsm_next = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_round <= '0;
            r_last  <= 1'b0;
`ifdef ASCON_AD_PAD_EN
            r_full  <= 1'b0;
`endif
        end else begin
            r_fsm   <= w_fsm_next;
            r_state <= w_state_next;
            r_round <= w_round_next;
            r_last  <= w_last_next;
`ifdef ASCON_AD_PAD_EN
            r_full  <= w_full_next;
`endif
        end
    end

    assign ad_ready_o = (r_fsm == ST_WAIT_AD);
    assign busy_o     = (r_fsm != ST_IDLE);
    assign done_o     = (r_fsm == ST_DONE);
    assign intr_o     = done_o;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ascon_ad_absorb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_ad_absorb
// Description : Self-checking bench for ascon_ad_absorb. Expected final
//               states come from a bit-sliced software round model or from
//               hand constants; a monitor compares them on every done_o.
//               Builds with or without ASCON_AD_PAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_ad_absorb;
    import ascon_pkg::*;

    localparam int ROUNDS_B = 6;

    logic         clk_i      = 1'b0;
    logic         rst_n_i    = 1'b0;
    logic         start_i    = 1'b0;
    ascon_state_t state_i    = '0;
    logic [127:0] key_i      = '0;
    logic         ad_empty_i = 1'b0;
    logic         ad_valid_i = 1'b0;
    logic [63:0]  ad_data_i  = '0;
    logic         ad_last_i  = 1'b0;
`ifdef ASCON_AD_PAD_EN
    logic [3:0]   ad_bytes_i = '0;
`endif
    logic         ad_ready_o;
    logic         busy_o;
    logic         done_o;
    logic         intr_o;
    ascon_state_t state_o;

    ascon_ad_absorb #(.ROUNDS_B(ROUNDS_B)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (start_i),
        .state_i    (state_i),
        .key_i      (key_i),
        .ad_empty_i (ad_empty_i),
        .ad_valid_i (ad_valid_i),
        .ad_ready_o (ad_ready_o),
        .ad_data_i  (ad_data_i),
        .ad_last_i  (ad_last_i),
`ifdef ASCON_AD_PAD_EN
        .ad_bytes_i (ad_bytes_i),
`endif
        .busy_o     (busy_o),
        .done_o     (done_o),
        .state_o    (state_o),
        .intr_o     (intr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        ascon_state_t st;
        int           lat;        // expected cycles start-edge -> done, -1 = unchecked
        int           start_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_assert  = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          done_cnt  = 0;
    bit          done_prev = 1'b0;

    // Padded blocks seen by the model, and blocks driven onto the AD port
    logic [63:0] mdl_blk [4];
    int          n_mdl;
    logic [63:0] dut_data [4];
    logic [3:0]  dut_bytes [4];
    int          n_dut;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference round in the bit-sliced instruction form of the C code
    function automatic ascon_state_t mdl_round(input ascon_state_t s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        ascon_state_t o;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x2 = x2 ^ 64'((15 - r) * 16 + r);
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = x0 ^ (~x1 & x2);
        t1 = x1 ^ (~x2 & x3);
        t2 = x2 ^ (~x3 & x4);
        t3 = x3 ^ (~x4 & x0);
        t4 = x4 ^ (~x0 & x1);
        t1 ^= t0; t0 ^= t4; t3 ^= t2; t2 = ~t2;
        o[0] = t0 ^ ror(t0, 19) ^ ror(t0, 28);
        o[1] = t1 ^ ror(t1, 61) ^ ror(t1, 39);
        o[2] = t2 ^ ror(t2, 1)  ^ ror(t2, 6);
        o[3] = t3 ^ ror(t3, 10) ^ ror(t3, 17);
        o[4] = t4 ^ ror(t4, 7)  ^ ror(t4, 41);
        return o;
    endfunction

    function automatic ascon_state_t mdl_msg(input ascon_state_t init, input logic [127:0] key);
        ascon_state_t s;
        s = init;
        s[3] ^= key[127:64];
        s[4] ^= key[63:0];
        for (int i = 0; i < n_mdl; i++) begin
            s[0] ^= mdl_blk[i];
            for (int r = 12 - ROUNDS_B; r < 12; r++) s = mdl_round(s, r);
        end
        s[4][0] = s[4][0] ^ 1'b1;
        return s;
    endfunction

    task automatic set_mdl(input int n, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        n_mdl = n; mdl_blk[0] = a; mdl_blk[1] = b; mdl_blk[2] = c; mdl_blk[3] = '0;
    endtask

    // Raw blocks + byte counts in the padding build, model blocks otherwise
    task automatic set_dut(input int n, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                           input logic [3:0] ba, input logic [3:0] bb, input logic [3:0] bc);
`ifdef ASCON_AD_PAD_EN
        n_dut = n; dut_data[0] = a; dut_data[1] = b; dut_data[2] = c;
        dut_bytes[0] = ba; dut_bytes[1] = bb; dut_bytes[2] = bc;
`else
        n_dut = n_mdl;
        for (int i = 0; i < 4; i++) begin
            dut_data[i]  = mdl_blk[i];
            dut_bytes[i] = (i == 0) ? ba : ((i == 1) ? bb : bc);
        end
        if (n > 4) n_dut = n_mdl;
        if (a === b && b === c) n_dut = n_mdl;
`endif
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy_o && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        check("idle_after_done", busy_o, 1'b0);
    endtask

    task automatic drive_msg(input ascon_state_t init, input logic [127:0] key, input bit empty,
                             input ascon_state_t exp_st, input int gap, input bit noise);
        exp_t e;
        int   t;
        bit   lo_ok;
        e.st  = exp_st;
        e.lat = empty ? 0 : ((gap == 0) ? 7 * n_mdl : -1);
        @(negedge clk_i);
        state_i = init; key_i = key; ad_empty_i = empty; start_i = 1'b1;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk_i);
        start_i    = 1'b0;
        state_i    = {5{64'hDEAD_BEEF_0BAD_F00D}};
        key_i      = ~key;
        ad_empty_i = ~empty;
        if (!empty) begin
            for (int b = 0; b < n_dut; b++) begin
                ad_valid_i = 1'b1;
                ad_data_i  = dut_data[b];
                ad_last_i  = (b == n_dut - 1);
`ifdef ASCON_AD_PAD_EN
                ad_bytes_i = dut_bytes[b];
`endif
                t = 0;
                while (!ad_ready_o && t < 100) begin
                    start_i = noise;
                    @(negedge clk_i);
                    t++;
                end
                if (t >= 100) check("ready_timeout", 1'b0, 1'b1);
                start_i = noise;
                @(negedge clk_i);
                start_i    = 1'b0;
                ad_valid_i = 1'b0;
                ad_data_i  = 64'hFFFF_0000_FFFF_0000;
                if (gap > 0) begin
                    lo_ok = 1'b1;
                    for (int r = 0; r < ROUNDS_B; r++) begin
                        if (ad_ready_o) lo_ok = 1'b0;
                        start_i = noise;
                        @(negedge clk_i);
                    end
                    start_i = 1'b0;
                    check("ready_low_in_perm", lo_ok, 1'b1);
                    if (b < n_dut - 1) begin
                        repeat (gap) begin
                            start_i = noise;
                            @(negedge clk_i);
                        end
                        start_i = 1'b0;
                    end
                end
            end
        end
        ad_last_i = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk_i);
        check("state_hold", state_o, exp_st);
    endtask

    // Scoreboard monitor: every done_o pulse consumes one expectation
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_n_i) begin
            done_prev = 1'b0;
        end else begin
            if (done_o) begin
                done_cnt++;
                check("done_pulse_width", done_prev, 1'b0);
                if (sb.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_done: done_o=1 with no message outstanding");
                end else begin
                    e = sb.pop_front();
                    check("state_o", state_o, e.st);
                    check("intr_o", intr_o, 1'b1);
                    if (e.lat >= 0) check("done_latency", 320'(cyc - e.start_cyc), 320'(e.lat));
                end
            end
            done_prev = done_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ascon_state_t s_a, s_b, zero_st, exp_st;
        logic [127:0] k_a, k_b;
        int           d0;
        s_a  = {64'h4444_5555_6666_7777, 64'h3333_2222_1111_0000, 64'h0F0E_0D0C_0B0A_0908,
                64'h8899_AABB_CCDD_EEFF, 64'h0123_4567_89AB_CDEF};
        s_b  = {64'hA5A5_5A5A_C3C3_3C3C, 64'h1357_9BDF_2468_ACE0, 64'hFEDC_BA98_7654_3210,
                64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000};
        k_a  = 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
        k_b  = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;
        zero_st = '0;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ready", ad_ready_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_intr", intr_o, 1'b0);
        check("rst_state", state_o, zero_st);
        rst_n_i = 1'b1;

        // Empty AD, all-zero inputs: only the domain bit lands in x4
        exp_st = '0;
        exp_st[4] = 64'h1;
        n_mdl = 0; n_dut = 0;
        drive_msg(zero_st, '0, 1'b1, exp_st, 0, 1'b0);

        // Empty AD with key mixing
        set_mdl(0, '0, '0, '0);
        drive_msg(s_a, k_a, 1'b1, mdl_msg(s_a, k_a), 0, 1'b0);

        // Full last block: absorbed as-is then a 0x80.. padding block
        set_mdl(2, 64'h0001_0203_0405_0607, 64'h8000_0000_0000_0000, '0);
        set_dut(1, 64'h0001_0203_0405_0607, '0, '0, 4'd8, 4'd0, 4'd0);
        drive_msg(s_a, k_a, 1'b0, mdl_msg(s_a, k_a), 0, 1'b0);

        // Partial last block, 3 bytes: garbage above byte 3 is cleared
        set_mdl(1, 64'hAABB_CC80_0000_0000, '0, '0);
        set_dut(1, 64'hAABB_CCFF_FFFF_FFFF, '0, '0, 4'd3, 4'd0, 4'd0);
        drive_msg(s_b, k_b, 1'b0, mdl_msg(s_b, k_b), 0, 1'b0);

        // Zero-byte last block: pure padding word
        set_mdl(1, 64'h8000_0000_0000_0000, '0, '0);
        set_dut(1, 64'h5A5A_5A5A_5A5A_5A5A, '0, '0, 4'd0, 4'd0, 4'd0);
        drive_msg(s_a, k_b, 1'b0, mdl_msg(s_a, k_b), 0, 1'b0);

        // Three blocks back-to-back; byte counts on non-last blocks are don't-care
        set_mdl(3, 64'h1111_1111_1111_1111, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_8000_0000);
        set_dut(3, 64'h1111_1111_1111_1111, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_FFFF_FFFF,
                4'd2, 4'd5, 4'd4);
        drive_msg(s_b, k_a, 1'b0, mdl_msg(s_b, k_a), 0, 1'b0);

        // Same three blocks with 5-cycle gaps between them
        drive_msg(s_b, k_a, 1'b0, mdl_msg(s_b, k_a), 5, 1'b0);

        // Same again with start_i pulsed in WAIT_AD and PERM
        drive_msg(s_b, k_a, 1'b0, mdl_msg(s_b, k_a), 5, 1'b1);

        // Reset in the middle of the permutation
        set_mdl(1, 64'hAABB_CC80_0000_0000, '0, '0);
        set_dut(1, 64'hAABB_CCFF_FFFF_FFFF, '0, '0, 4'd3, 4'd0, 4'd0);
        @(negedge clk_i);
        state_i = s_a; key_i = k_a; ad_empty_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i    = 1'b0;
        ad_valid_i = 1'b1;
        ad_data_i  = dut_data[0];
        ad_last_i  = 1'b1;
`ifdef ASCON_AD_PAD_EN
        ad_bytes_i = dut_bytes[0];
`endif
        @(negedge clk_i);
        ad_valid_i = 1'b0;
        ad_last_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        d0 = done_cnt;
        #2 rst_n_i = 1'b0;
        #1;
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_ready", ad_ready_o, 1'b0);
        check("mid_rst_done", done_o, 1'b0);
        check("mid_rst_intr", intr_o, 1'b0);
        check("mid_rst_state", state_o, zero_st);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (20) @(negedge clk_i);
        check("no_done_after_reset", 320'(done_cnt), 320'(d0));
        drive_msg(s_a, k_a, 1'b0, mdl_msg(s_a, k_a), 0, 1'b0);

        repeat (5) @(negedge clk_i);
        check("scoreboard_drained", 320'(sb.size()), 320'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
